// File: rtl/gs_prefetch_buffer.sv
`timescale 1ns/1ps
// gs_prefetch_buffer
// Sequential instruction prefetcher sitting between the fetch stage and the
// instruction memory port. Keeps up to MAX_OUT requests in flight and buffers
// returned words in a DEPTH-entry FIFO. A redirect flushes the FIFO and marks
// every response still due (including an ungranted pending request) as stale.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   fetch_en_i               permits new memory requests
//   redirect_i/_addr_i       one-cycle flush + restart at new PC (bits [1:0] ignored)
//   valid_o/instr_o/pc_o/err_o  FIFO head; popped on valid_o & ready_i
//   instr_req_o/_addr_o      memory request (held stable until grant)
//   instr_gnt_i              request accepted
//   instr_rvalid_i/_rdata_i/_err_i  in-order memory response
//   busy_o                   requests outstanding or a request pending
module gs_prefetch_buffer #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MAX_OUT   = 2,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fetch_en_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            err_o,
  input  logic            ready_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [31:0]     instr_rdata_i,
  input  logic            instr_err_i,
  output logic            busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 2);
  localparam int unsigned SW = CW + OW;

  typedef enum logic [1:0] {INITIAL, PENDING, FETCHING} pf_state_t;

  pf_state_t       state_q;
  logic            req_q;
  logic [XLEN-1:0] req_addr_q;

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d, disc_cnt_q, disc_cnt_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d, resp_pc_q, resp_pc_d;
  logic            halted_q, halted_d;
  logic            stale_q, stale_d;   // pending request predates the last redirect

  logic            grant, push, pop, issue_ok;
  logic [XLEN-1:0] redir_pc;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic            err_mem   [DEPTH];

  assign redir_pc = redirect_addr_i & ~XLEN'(3);
  assign grant    = req_q & instr_gnt_i;
  // Redirect wins over a same-cycle push or pop: the FIFO is cleared anyway.
  assign push     = instr_rvalid_i & (disc_cnt_q == '0) & ~redirect_i;
  assign pop      = (fifo_cnt_q != '0) & ready_i & ~redirect_i;

  always_comb begin
    out_cnt_d    = out_cnt_q + OW'(grant) - OW'(instr_rvalid_i);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    wr_ptr_d     = wr_ptr_q + PW'(push);
    fifo_cnt_d   = fifo_cnt_q + CW'(push) - CW'(pop);
    disc_cnt_d   = disc_cnt_q;
    stale_d      = stale_q;
    fetch_addr_d = fetch_addr_q;
    resp_pc_d    = resp_pc_q;
    halted_d     = halted_q;

    if (instr_rvalid_i && disc_cnt_q != '0) disc_cnt_d = disc_cnt_q - OW'(1);
    if (grant) stale_d = 1'b0;
    // A stale request was already addressed before the redirect; it must not
    // advance the post-redirect fetch address.
    if (grant && !stale_q) fetch_addr_d = fetch_addr_q + XLEN'(4);
    if (push) resp_pc_d = resp_pc_q + XLEN'(4);
    if (push && instr_err_i) halted_d = 1'b1;

    if (redirect_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      fifo_cnt_d   = '0;
      // Everything still due is stale: in flight after this edge, plus a
      // pending request that was not granted this cycle.
      disc_cnt_d   = out_cnt_d + OW'(req_q & ~instr_gnt_i);
      stale_d      = req_q & ~instr_gnt_i;
      fetch_addr_d = redir_pc;
      resp_pc_d    = redir_pc;
      halted_d     = 1'b0;
    end

    // Evaluated on next-state values so that a request raised now can never
    // exceed MAX_OUT nor overflow the FIFO once granted and answered.
    issue_ok = fetch_en_i && !halted_d && (out_cnt_d < OW'(MAX_OUT)) &&
               ((SW'(fifo_cnt_d) + SW'(out_cnt_d)) < SW'(DEPTH));
  end

  // Request controller: request and address are registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INITIAL;
      req_q      <= 1'b0;
      req_addr_q <= BOOT_ADDR;
    end else begin
      case (state_q)
        INITIAL: begin
          if (issue_ok) begin
            state_q    <= PENDING;
            req_q      <= 1'b1;
            req_addr_q <= fetch_addr_d;
          end
        end
        PENDING: begin
          // Held until granted, regardless of fetch_en_i or redirects.
          if (instr_gnt_i) begin
            if (issue_ok) begin
              req_addr_q <= fetch_addr_d;
            end else begin
              state_q <= FETCHING;
              req_q   <= 1'b0;
            end
          end
        end
        FETCHING: begin
          if (issue_ok) begin
            state_q    <= PENDING;
            req_q      <= 1'b1;
            req_addr_q <= fetch_addr_d;
          end else if (out_cnt_d == '0) begin
            state_q <= INITIAL;
          end
        end
        default: begin
          state_q <= INITIAL;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      out_cnt_q    <= '0;
      disc_cnt_q   <= '0;
      fetch_addr_q <= BOOT_ADDR;
      resp_pc_q    <= BOOT_ADDR;
      halted_q     <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      out_cnt_q    <= out_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
      fetch_addr_q <= fetch_addr_d;
      resp_pc_q    <= resp_pc_d;
      halted_q     <= halted_d;
      stale_q      <= stale_d;
    end
  end

  // FIFO storage, one register set per entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic            err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        instr_q <= '0;
        pc_q    <= '0;
        err_q   <= 1'b0;
      end else if (push && wr_ptr_q == PW'(gi)) begin
        instr_q <= instr_rdata_i;
        pc_q    <= resp_pc_q;
        err_q   <= instr_err_i;
      end
    end

    assign instr_mem[gi] = instr_q;
    assign pc_mem[gi]    = pc_q;
    assign err_mem[gi]   = err_q;
  end

  assign valid_o      = (fifo_cnt_q != '0);
  assign instr_o      = valid_o ? instr_mem[rd_ptr_q] : '0;
  assign pc_o         = valid_o ? pc_mem[rd_ptr_q] : '0;
  assign err_o        = valid_o & err_mem[rd_ptr_q];
  assign instr_req_o  = req_q;
  assign instr_addr_o = req_addr_q;
  assign busy_o       = (out_cnt_q != '0) | req_q;

endmodule

// File: tb/tb_gs_prefetch_buffer.sv
`timescale 1ns/1ps
// Directed bench for gs_prefetch_buffer: in-order memory model with
// controllable grant/response gating, linear stimulus, immediate assertions.
module tb_gs_prefetch_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        ready = 1'b0;
  logic        valid_o, err_o, instr_req_o, busy_o;
  logic [31:0] instr_o, pc_o, instr_addr_o;
  logic        instr_gnt;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rerr = 1'b0;

  logic        gnt_en = 1'b1;
  logic        resp_en = 1'b1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  logic [31:0] exp_pc = '0;
  int          g0;

  logic [31:0] pend_q[$];
  logic [31:0] grant_log[$];

  always #5 clk_i = ~clk_i;

  gs_prefetch_buffer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetch_en_i(fetch_en),
    .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .err_o(err_o),
    .ready_i(ready), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt), .instr_rvalid_i(mem_rvalid),
    .instr_rdata_i(mem_rdata), .instr_err_i(mem_rerr), .busy_o(busy_o)
  );

  assign instr_gnt = instr_req_o & gnt_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] glog(input int i);
    if (i >= 0 && i < grant_log.size()) return grant_log[i];
    return 32'hDEADBEEF;
  endfunction

  // Memory: records grants at the edge, answers one request per cycle in order.
  always begin
    @(posedge clk_i);
    if (!rst_ni) begin
      pend_q.delete();
    end else if (instr_req_o && instr_gnt) begin
      pend_q.push_back(instr_addr_o);
      grant_log.push_back(instr_addr_o);
    end
    #1;
    if (rst_ni && resp_en && pend_q.size() > 0) begin
      mem_rdata  = mem_word(pend_q[0]);
      mem_rerr   = err_en && (pend_q[0] == err_addr);
      mem_rvalid = 1'b1;
      void'(pend_q.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      mem_rerr   = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the head against the expected sequential PC; caller holds ready=1.
  task automatic pop_check(input string tag, input logic exp_err);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_pc"}, pc_o, exp_pc);
    chk({tag, "_instr"}, instr_o, mem_word(exp_pc));
    chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
    $display("pop %s pc=%0h instr=%0h err=%0b", tag, pc_o, instr_o, err_o);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30 && valid_o !== 1'b1; i++) tick();
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect = 1'b1;
    redirect_addr = a;
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_addr", instr_addr_o, 32'd0);

    // Streaming from boot address, 1-cycle memory
    fetch_en = 1'b1;
    ready = 1'b1;
    rst_ni = 1'b1;
    tick();
    chk("t1_req", 32'(instr_req_o), 32'd1);
    chk("t1_addr0", instr_addr_o, 32'h0);
    tick();
    chk("t1_novalid", 32'(valid_o), 32'd0);
    chk("t1_addr4", instr_addr_o, 32'h4);
    tick();
    for (int i = 0; i < 8; i++) begin
      pop_check("stream", 1'b0);
      tick();
    end

    // Back-pressure: fill to DEPTH, then one pop frees exactly one request
    ready = 1'b0;
    repeat (12) tick();
    chk("t2_full_valid", 32'(valid_o), 32'd1);
    chk("t2_full_req", 32'(instr_req_o), 32'd0);
    chk("t2_full_busy", 32'(busy_o), 32'd0);
    chk("t2_hold_pc", pc_o, exp_pc);
    g0 = grant_log.size();
    ready = 1'b1;
    pop_check("t2_pop1", 1'b0);
    tick();
    ready = 1'b0;
    repeat (10) tick();
    chk("t2_one_req", 32'(grant_log.size() - g0), 32'd1);
    fetch_en = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pop_check("t2_drain", 1'b0);
      tick();
    end
    chk("t2_empty", 32'(valid_o), 32'd0);

    // Redirect with two responses outstanding
    resp_en = 1'b0;
    g0 = grant_log.size();
    fetch_en = 1'b1;
    repeat (5) tick();
    chk("t3_two_out", 32'(grant_log.size() - g0), 32'd2);
    chk("t3_req_cap", 32'(instr_req_o), 32'd0);
    chk("t3_busy", 32'(busy_o), 32'd1);
    resp_en = 1'b1;
    do_redirect(32'h103);
    exp_pc = 32'h100;
    wait_valid();
    chk("t3_pc100", pc_o, 32'h100);
    chk("t3_instr100", instr_o, 32'hC0DE0100);
    pop_check("t3_redir", 1'b0);

    // Redirect while a request to 0x20 waits for grant
    fetch_en = 1'b0;
    repeat (10) tick();
    chk("t4_idle_valid", 32'(valid_o), 32'd0);
    chk("t4_idle_busy", 32'(busy_o), 32'd0);
    gnt_en = 1'b0;
    fetch_en = 1'b1;
    do_redirect(32'h20);
    chk("t4_req20", 32'(instr_req_o), 32'd1);
    chk("t4_addr20", instr_addr_o, 32'h20);
    repeat (2) tick();
    do_redirect(32'h200);
    chk("t4_held_req", 32'(instr_req_o), 32'd1);
    chk("t4_held_addr", instr_addr_o, 32'h20);
    g0 = grant_log.size();
    gnt_en = 1'b1;
    tick();
    chk("t4_gnt20", glog(g0), 32'h20);
    tick();
    chk("t4_gnt200", glog(g0 + 1), 32'h200);
    exp_pc = 32'h200;
    wait_valid();
    pop_check("t4_first", 1'b0);

    // Bus error on 0x8 halts fetching until a redirect
    fetch_en = 1'b0;
    repeat (10) tick();
    err_en = 1'b1;
    err_addr = 32'h8;
    fetch_en = 1'b1;
    do_redirect(32'h0);
    exp_pc = 32'h0;
    wait_valid();
    pop_check("t5_e0", 1'b0);
    tick();
    pop_check("t5_e4", 1'b0);
    tick();
    pop_check("t5_e8", 1'b1);
    tick();
    pop_check("t5_eC", 1'b0);
    repeat (8) tick();
    chk("t5_halt_req", 32'(instr_req_o), 32'd0);
    chk("t5_halt_busy", 32'(busy_o), 32'd0);
    chk("t5_halt_valid", 32'(valid_o), 32'd0);
    chk("t5_last_gnt", glog(grant_log.size() - 1), 32'hC);
    err_en = 1'b0;
    do_redirect(32'h40);
    exp_pc = 32'h40;
    wait_valid();
    pop_check("t5_resume", 1'b0);

    // Delayed grant with fetch_en toggled low, then a delayed response
    fetch_en = 1'b0;
    repeat (10) tick();
    do_redirect(32'h300);
    chk("t6_noreq", 32'(instr_req_o), 32'd0);
    ready = 1'b0;
    gnt_en = 1'b0;
    fetch_en = 1'b1;
    tick();
    chk("t6_req", 32'(instr_req_o), 32'd1);
    chk("t6_addr_a", instr_addr_o, 32'h300);
    fetch_en = 1'b0;
    tick();
    chk("t6_addr_b", instr_addr_o, 32'h300);
    chk("t6_req_b", 32'(instr_req_o), 32'd1);
    tick();
    chk("t6_addr_c", instr_addr_o, 32'h300);
    gnt_en = 1'b1;
    resp_en = 1'b0;
    tick();
    chk("t6_req_drop", 32'(instr_req_o), 32'd0);
    chk("t6_busy_a", 32'(busy_o), 32'd1);
    tick();
    chk("t6_busy_b", 32'(busy_o), 32'd1);
    resp_en = 1'b1;
    tick();
    chk("t6_busy_c", 32'(busy_o), 32'd1);
    chk("t6_novalid", 32'(valid_o), 32'd0);
    tick();
    chk("t6_busy_off", 32'(busy_o), 32'd0);
    chk("t6_valid", 32'(valid_o), 32'd1);
    chk("t6_pc", pc_o, 32'h300);
    chk("t6_instr", instr_o, 32'hC0DE0300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gs_prefetch_buffer.md
# gs_prefetch_buffer

Parametrised instruction prefetch unit between the fetch stage and the instruction memory port. Issues sequential word fetches ahead of the decoder over a request/grant/rvalid memory interface, keeps up to `MAX_OUT` requests in flight, and buffers returned words in a `DEPTH`-entry FIFO. Handles PC redirects (branch/jump) by flushing the FIFO and discarding stale in-flight responses. Controller state names follow `pf_state_t` (`INITIAL`, `PENDING`, `FETCHING`).

## Interface
- `XLEN`, 32: address/PC width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `MAX_OUT`, 2: maximum outstanding granted-but-unanswered requests; 1..`DEPTH`.
- `BOOT_ADDR`, `'0`: fetch address after reset; bits [1:0] must be 0.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `fetch_en_i`  in  1  permits new memory requests.
- `redirect_i`  in  1  one-cycle pulse: flush and restart at `redirect_addr_i`.
- `redirect_addr_i`  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0).
- `valid_o`  out  1  FIFO head valid.
- `instr_o`  out  32  head instruction word.
- `pc_o`  out  XLEN  head PC.
- `err_o`  out  1  head entry carries a bus error.
- `ready_i`  in  1  consumer pops the head when `valid_o & ready_i`.
- `instr_req_o`  out  1  memory request.
- `instr_addr_o`  out  XLEN  request address, word aligned.
- `instr_gnt_i`  in  1  request accepted this cycle.
- `instr_rvalid_i`  in  1  response valid; responses return in request order.
- `instr_rdata_i`  in  32  response data.
- `instr_err_i`  in  1  response error, qualified by `instr_rvalid_i`.
- `busy_o`  out  1  outstanding count ≠ 0 or `instr_req_o` high.

## Operation
- Internal state: FIFO {pc, instr, err}, `fetch_addr`, `resp_pc`, outstanding counter `out_cnt` (0..`MAX_OUT`), discard counter `disc_cnt`, `halted` flag, FSM.
- FSM:
  - `INITIAL`: no request. Moves to `PENDING` when issue is allowed.
  - `PENDING`: `instr_req_o`=1, address = `fetch_addr`. On grant, moves to `FETCHING`, or stays in `PENDING` if issue is still allowed.
  - `FETCHING`: waiting for responses only. Moves to `PENDING` when issue is allowed, or to `INITIAL` when `out_cnt` = 0 and issue is not allowed.
- Issue allowed when all of the following hold: `fetch_en_i`, `!halted`, `out_cnt < MAX_OUT`, and FIFO count + `out_cnt` < `DEPTH`. The last term is a credit check that guarantees the FIFO never overflows.
- Protocol rule: once `instr_req_o` rises, it and `instr_addr_o` stay stable until `instr_gnt_i`. Deasserting `fetch_en_i` or a redirect never retracts a pending request.
- Grant: `out_cnt`++, `fetch_addr` += 4 (wraps mod 2^XLEN).
- Response with `disc_cnt` > 0: `disc_cnt`−−, `out_cnt`−−; no push.
- Response with `disc_cnt` = 0: push {`resp_pc`, data, err}, `resp_pc` += 4, `out_cnt`−−.
- Error response pushed: set `halted`, so no further requests issue. Later non-discarded responses are still pushed.
- Redirect, all in one edge:
  - FIFO cleared.
  - `fetch_addr` and `resp_pc` set to `redirect_addr_i & ~3`.
  - `halted` cleared.
  - `disc_cnt` set to the number of stale responses still due: outstanding after this cycle's grant/response, plus 1 if a request is pending and not granted.
  - A pending ungranted request keeps its old address. It is re-marked stale, and `fetch_addr` advances only for post-redirect grants.
- Simultaneous events:
  - Redirect beats a same-cycle pop and push; a same-cycle response is discarded or counted accordingly.
  - Push and pop in the same cycle are legal at any fill level.

## Timing
- Reset values:
  - Outputs: `valid_o`, `instr_req_o`, `busy_o`, `err_o` = 0; `instr_o` = 0; `pc_o` = 0; `instr_addr_o` = `BOOT_ADDR`.
  - Internal: `out_cnt` = `disc_cnt` = 0; FSM = `INITIAL`; `fetch_addr` = `resp_pc` = `BOOT_ADDR`.
- `instr_req_o` is registered: it rises one cycle after issue is allowed.
- Data latency: response in cycle N → `valid_o` in N+1. No combinational path from `instr_rvalid_i` to `valid_o`.
- Head outputs hold stable while `valid_o & !ready_i`.
- Full throughput: with `MAX_OUT` ≥ 2 and a 1-cycle memory, one word per cycle is sustained.
- An asserted reset mid-transaction drops everything. The memory side must also be reset.

## Test plan
- Reset, `fetch_en_i`=1, 1-cycle grant/response memory, `ready_i`=1 → `pc_o` sequence 0x0, 0x4, 0x8…; `valid_o` continuous from the 3rd cycle after the first request.
- `ready_i`=0, `DEPTH`=4 → exactly 4 entries buffered, then `instr_req_o` stays 0; one pop → exactly one new request.
- Redirect to 0x103 while 2 requests are outstanding → both responses dropped; next `pc_o` = 0x100 with `instr_o` = mem[0x100].
- Redirect during an ungranted request at 0x20 → request to 0x20 stays asserted until grant; its response is dropped; the following request is to the redirect target.
- `instr_err_i`=1 on the response for 0x8 → entry for 0x8 has `err_o`=1, then no new requests; redirect to 0x40 → fetching resumes from 0x40.
- Grant delayed 3 cycles with `fetch_en_i` toggled low → `instr_addr_o` held constant until grant; `busy_o` drops only after the last response.
